// File: rtl/t_route_stage.sv
// Datapath and route-decode half of a BFT t-switch: registers the three input links,
// decodes wanted directions for the arbiter, muxes on its selects and tracks deflections/errors.
module t_route_stage #(
  parameter int PACKET_BITS = 49,
  parameter int ADDR_BITS   = 5,
  parameter int LEVEL       = 1,
  parameter logic [ADDR_BITS-LEVEL-1:0] SW_ID = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PACKET_BITS-1:0] l_in,
  input  logic [PACKET_BITS-1:0] r_in,
  input  logic [PACKET_BITS-1:0] u_in,
  output logic [1:0]             d_l,
  output logic [1:0]             d_r,
  output logic [1:0]             d_u,
  input  logic [1:0]             sel_l,
  input  logic [1:0]             sel_r,
  input  logic [1:0]             sel_u,
  output logic [PACKET_BITS-1:0] l_out,
  output logic [PACKET_BITS-1:0] r_out,
  output logic [PACKET_BITS-1:0] u_out,
  output logic [15:0]            defl_cnt,
  output logic                   route_err
);

  localparam logic [1:0] DIR_VOID  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  logic [PACKET_BITS-1:0] pkt_l_p1, pkt_r_p1, pkt_u_p1;
  logic [1:0]             defl_now;
  logic                   err_now;

  function automatic logic [1:0] decode_dir(input logic vld, input logic [ADDR_BITS-1:0] addr);
    if (!vld)
      decode_dir = DIR_VOID;
    else if (addr[ADDR_BITS-1:LEVEL] != SW_ID)
      decode_dir = DIR_UP;
    else
      decode_dir = addr[LEVEL-1] ? DIR_RIGHT : DIR_LEFT;
  endfunction

  // A select naming a VOID source yields an all-zero packet, never stale payload bits.
  function automatic logic [PACKET_BITS-1:0] select_pkt(
    input logic [1:0] sel, input logic [1:0] dl, input logic [1:0] dr, input logic [1:0] du,
    input logic [PACKET_BITS-1:0] pl, input logic [PACKET_BITS-1:0] pr,
    input logic [PACKET_BITS-1:0] pu);
    select_pkt = '0;
    case (sel)
      DIR_LEFT:  if (dl != DIR_VOID) select_pkt = pl;
      DIR_RIGHT: if (dr != DIR_VOID) select_pkt = pr;
      DIR_UP:    if (du != DIR_VOID) select_pkt = pu;
      default:   select_pkt = '0;
    endcase
  endfunction

  function automatic logic is_defl(input logic [1:0] sel, input logic [1:0] own,
    input logic [1:0] dl, input logic [1:0] dr, input logic [1:0] du);
    logic [1:0] ds;
    case (sel)
      DIR_LEFT:  ds = dl;
      DIR_RIGHT: ds = dr;
      DIR_UP:    ds = du;
      default:   ds = DIR_VOID;
    endcase
    is_defl = (sel != DIR_VOID) && (ds != DIR_VOID) && (ds != own);
  endfunction

  // A live packet must be named by exactly one select: zero drops it, two or more duplicate it.
  function automatic logic src_err(input logic [1:0] code, input logic [1:0] d,
    input logic [1:0] sl, input logic [1:0] sr, input logic [1:0] su);
    logic [1:0] hits;
    hits = {1'b0, sl == code} + {1'b0, sr == code} + {1'b0, su == code};
    src_err = (d != DIR_VOID) && (hits != 2'd1);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'b0, inc};
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign d_l = decode_dir(pkt_l_p1[PACKET_BITS-1], pkt_l_p1[PACKET_BITS-2 -: ADDR_BITS]);
  assign d_r = decode_dir(pkt_r_p1[PACKET_BITS-1], pkt_r_p1[PACKET_BITS-2 -: ADDR_BITS]);
  assign d_u = decode_dir(pkt_u_p1[PACKET_BITS-1], pkt_u_p1[PACKET_BITS-2 -: ADDR_BITS]);

  always_comb begin
    defl_now = {1'b0, is_defl(sel_l, DIR_LEFT,  d_l, d_r, d_u)}
             + {1'b0, is_defl(sel_r, DIR_RIGHT, d_l, d_r, d_u)}
             + {1'b0, is_defl(sel_u, DIR_UP,    d_l, d_r, d_u)};
    err_now  = src_err(DIR_LEFT,  d_l, sel_l, sel_r, sel_u)
             | src_err(DIR_RIGHT, d_r, sel_l, sel_r, sel_u)
             | src_err(DIR_UP,    d_u, sel_l, sel_r, sel_u);
  end

  // Stage 1: capture input links
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_l_p1 <= '0;
      pkt_r_p1 <= '0;
      pkt_u_p1 <= '0;
    end else begin
      pkt_l_p1 <= l_in;
      pkt_r_p1 <= r_in;
      pkt_u_p1 <= u_in;
    end
  end

  // Stage 2: output links, deflection count and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_out     <= '0;
      r_out     <= '0;
      u_out     <= '0;
      defl_cnt  <= '0;
      route_err <= 1'b0;
    end else begin
      l_out     <= select_pkt(sel_l, d_l, d_r, d_u, pkt_l_p1, pkt_r_p1, pkt_u_p1);
      r_out     <= select_pkt(sel_r, d_l, d_r, d_u, pkt_l_p1, pkt_r_p1, pkt_u_p1);
      u_out     <= select_pkt(sel_u, d_l, d_r, d_u, pkt_l_p1, pkt_r_p1, pkt_u_p1);
      defl_cnt  <= sat_add(defl_cnt, defl_now);
      route_err <= route_err | err_now;
    end
  end

endmodule
